// File: rtl/exec_stage.sv
// exec_stage: execute stage with single-cycle ALU, bit-serial shifter and optional bit-serial multiplier.
// Optional multiplier is built only when EXEC_STAGE_MUL_EN is defined; otherwise opcode 11 is illegal.
module exec_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [3:0]  in_d,
    input  logic [2:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_rd,
    output logic        out_we,
    output logic [3:0]  flags,
    output logic        illegal,
    output logic [1:0]  state
);

    // Handshake: a bundle moves on a rising edge with in_valid && in_ready (IDLE only); the result
    // is offered with out_valid in DONE and held stable until the edge where out_ready is high.

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SLR = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
`ifdef EXEC_STAGE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef EXEC_STAGE_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  op_q;
    logic [2:0]  rd_q;
    logic [15:0] work;
    logic [4:0]  cnt;
    logic        accept;
    logic        is_shift_in;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [15:0] fast_res;
    logic        fast_c;
    logic        fast_v;
    logic        fast_we;
    logic        fast_ill;
    logic [15:0] step_w;
    logic        step_c;
`ifdef EXEC_STAGE_MUL_EN
    logic [15:0] mcand;
    logic [15:0] acc_hi;
    logic [16:0] mul_add;
    logic [15:0] mul_lo;
`endif

    assign accept      = in_valid && in_ready;
    assign is_shift_in = (in_op >= OP_SLL) && (in_op <= OP_SRA);
    assign sum         = {1'b0, in_a} + {1'b0, in_b};
    assign diff        = {1'b0, in_a} - {1'b0, in_b};

    // Single-cycle results; logic ops and MOV report C=0, shifts with zero distance pass in_a through.
    always_comb begin
        fast_res = '0;
        fast_c   = 1'b0;
        fast_v   = 1'b0;
        fast_we  = 1'b1;
        fast_ill = 1'b0;
        case (in_op)
            OP_ADD: begin
                fast_res = sum[15:0];
                fast_c   = sum[16];
                fast_v   = (in_a[15] == in_b[15]) && (sum[15] != in_a[15]);
            end
            OP_SUB, OP_CMP: begin
                fast_res = diff[15:0];
                fast_c   = diff[16];
                fast_v   = (in_a[15] != in_b[15]) && (diff[15] != in_a[15]);
                fast_we  = (in_op == OP_SUB);
            end
            OP_AND: fast_res = in_a & in_b;
            OP_OR:  fast_res = in_a | in_b;
            OP_XOR: fast_res = in_a ^ in_b;
            OP_MOV: fast_res = in_b;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: fast_res = in_a;
`ifdef EXEC_STAGE_MUL_EN
            OP_MUL: fast_we = 1'b1;
`endif
            default: begin
                fast_we  = 1'b0;
                fast_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        step_w = work;
        step_c = 1'b0;
        case (op_q)
            OP_SLL: begin step_w = {work[14:0], 1'b0};     step_c = work[15]; end
            OP_SLR: begin step_w = {work[14:0], work[15]}; step_c = work[15]; end
            OP_SRL: begin step_w = {1'b0, work[15:1]};     step_c = work[0];  end
            OP_SRA: begin step_w = {work[15], work[15:1]}; step_c = work[0];  end
            default: ;
        endcase
    end

`ifdef EXEC_STAGE_MUL_EN
    // Shift-add: work holds the multiplier and shifts product low bits in from the top.
    assign mul_add = {1'b0, acc_hi} + (work[0] ? {1'b0, mcand} : 17'd0);
    assign mul_lo  = {mul_add[0], work[15:1]};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift_in && (in_d != 4'd0)) state_d = S_SHIFT;
`ifdef EXEC_STAGE_MUL_EN
                    else if (in_op == OP_MUL)          state_d = S_MUL;
`endif
                    else                               state_d = S_DONE;
                end
            end
            S_SHIFT: if (cnt == 5'd1) state_d = S_DONE;
`ifdef EXEC_STAGE_MUL_EN
            S_MUL:   if (cnt == 5'd1) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        state     = state_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= '0;
            rd_q       <= '0;
            work       <= '0;
            cnt        <= '0;
            out_result <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
            flags      <= '0;
            illegal    <= 1'b0;
`ifdef EXEC_STAGE_MUL_EN
            mcand      <= '0;
            acc_hi     <= '0;
`endif
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                op_q <= in_op;
                rd_q <= in_rd;
                cnt  <= {1'b0, in_d};
                work <= in_a;
`ifdef EXEC_STAGE_MUL_EN
                mcand  <= in_a;
                acc_hi <= '0;
                if (in_op == OP_MUL) begin
                    work <= in_b;
                    cnt  <= 5'd16;
                end
`endif
                if (state_d == S_DONE) begin
                    out_result <= fast_res;
                    out_rd     <= in_rd;
                    out_we     <= fast_we;
                    illegal    <= fast_ill;
                    if (!fast_ill) flags <= {fast_res[15], fast_res == 16'd0, fast_c, fast_v};
                end
            end else if (state_q == S_SHIFT) begin
                work <= step_w;
                cnt  <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    out_result <= step_w;
                    out_rd     <= rd_q;
                    out_we     <= 1'b1;
                    flags      <= {step_w[15], step_w == 16'd0, step_c, 1'b0};
                end
            end
`ifdef EXEC_STAGE_MUL_EN
            else if (state_q == S_MUL) begin
                acc_hi <= mul_add[16:1];
                work   <= mul_lo;
                cnt    <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    out_result <= mul_lo;
                    out_rd     <= rd_q;
                    out_we     <= 1'b1;
                    flags      <= {mul_lo[15], mul_lo == 16'd0, mul_add[16:1] != 16'd0, 1'b0};
                end
            end
`endif
        end
    end

endmodule
